// File: rtl/dmem_param.sv
// dmem_param: parameterised single-port data memory with a req/ready handshake, a read-valid
// strobe, out-of-range flagging and a clear engine that runs after reset. Define DMEM_WMASK_EN for byte-lane write masks.
module dmem_param #(
   parameter int                DATA_W  = 8,
   parameter int                ADDR_W  = 8,
   parameter int                DEPTH   = 256,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic                clk,
   input  logic                reset_dmem,
   input  logic                req,
   input  logic                we,
   input  logic [ADDR_W-1:0]   dmem_addr,
   input  logic [DATA_W-1:0]   wr_val,
`ifdef DMEM_WMASK_EN
   input  logic [DATA_W/8-1:0] wr_mask,
`endif
   output logic                ready,
   output logic [DATA_W-1:0]   data,
   output logic                data_valid,
   output logic                oob_err
);

   // Handshake: a request is taken on the rising edge where req && ready and reset_dmem is low.
   // While ready is low the request is ignored and nothing is queued.
   localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W:0]   clr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic              accept;
   logic              wr_en;
   logic              clr_en;
   logic [IDX_W-1:0]  acc_idx;
   logic [IDX_W-1:0]  clr_idx;

   assign ready    = (state == ST_IDLE);
   assign in_range = ({1'b0, dmem_addr} < DEPTH_V);
   assign accept   = req && ready && !reset_dmem;
   assign wr_en    = accept && we && in_range;
   assign clr_en   = (state == ST_CLEAR) && !reset_dmem;
   assign acc_idx  = dmem_addr[IDX_W-1:0];
   assign clr_idx  = clr_ptr[IDX_W-1:0];

   // Storage carries no reset; the clear engine initialises it one word per cycle.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_idx] <= CLR_VAL;
      end else if (wr_en) begin
`ifdef DMEM_WMASK_EN
         for (int i = 0; i < DATA_W/8; i++) begin
            if (wr_mask[i]) begin
               mem[acc_idx][8*i +: 8] <= wr_val[8*i +: 8];
            end
         end
`else
         mem[acc_idx] <= wr_val;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset_dmem) begin
         state      <= ST_CLEAR;
         clr_ptr    <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         oob_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         oob_err    <= 1'b0;
         case (state)
            ST_CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == LAST_PTR) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  oob_err <= !in_range;
                  if (!we) begin
                     // Out-of-range reads return zero rather than aliasing onto a real word.
                     data       <= in_range ? mem[acc_idx] : '0;
                     data_valid <= 1'b1;
                  end
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_param.sv
// tb_dmem_param: randomized scoreboard bench for dmem_param (DEPTH=16); a word-array
// reference model predicts ready, held data and every data_valid/oob_err strobe.
`timescale 1ns/1ps
module tb_dmem_param;

`ifdef DMEM_WMASK_EN
   localparam int DW      = 16;
   localparam bit MASK_EN = 1'b1;
`else
   localparam int DW      = 8;
   localparam bit MASK_EN = 1'b0;
`endif
   localparam int            AW    = 8;
   localparam int            DEPTH = 16;
   localparam int            MW    = DW / 8;
   localparam logic [DW-1:0] CLR   = '0;

   logic          clk = 1'b0;
   logic          reset_dmem;
   logic          req;
   logic          we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] wr_val;
   logic [MW-1:0] wr_mask;
   logic          ready;
   logic [DW-1:0] data;
   logic          data_valid;
   logic          oob_err;

   dmem_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLR_VAL(CLR)) dut (
      .clk        (clk),
      .reset_dmem (reset_dmem),
      .req        (req),
      .we         (we),
      .dmem_addr  (dmem_addr),
      .wr_val     (wr_val),
`ifdef DMEM_WMASK_EN
      .wr_mask    (wr_mask),
`endif
      .ready      (ready),
      .data       (data),
      .data_valid (data_valid),
      .oob_err    (oob_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model: plain word array; a clear completes DEPTH cycles after reset
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] model_data;
   int            clr_left;
   bit            started;

   // scoreboard entries: {is_read, oob, data}
   logic [DW+1:0] exp_q[$];
   int            checks;
   int            errors;

   function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] val,
                                           logic [MW-1:0] mask);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < MW; i++) begin
         if (mask[i] || !MASK_EN) r[8*i +: 8] = val[8*i +: 8];
      end
      return r;
   endfunction

   // driver: checks the state left by the previous edge, drives one cycle, advances the model
   task automatic drive(input bit rst, input bit rq, input bit w, input int addr,
                        input logic [DW-1:0] val, input logic [MW-1:0] mask);
      bit            oob;
      logic [DW-1:0] rd;
      @(negedge clk);
      if (started) begin
         checks++;
         if (ready !== (clr_left == 0)) begin
            errors++;
            $display("FAIL ready: got %b expected %b at %0t", ready, (clr_left == 0), $time);
         end
         checks++;
         if (data !== model_data) begin
            errors++;
            $display("FAIL data_hold: got %h expected %h at %0t", data, model_data, $time);
         end
      end
      reset_dmem = rst;
      req        = rq;
      we         = w;
      dmem_addr  = addr[AW-1:0];
      wr_val     = val;
      wr_mask    = mask;
      if (rst) begin
         started    = 1'b1;
         clr_left   = DEPTH;
         model_data = '0;
      end else if (started && clr_left > 0) begin
         clr_left--;
         if (clr_left == 0) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = CLR;
         end
      end else if (started && rq) begin
         oob = (addr >= DEPTH);
         if (w) begin
            if (!oob) model_mem[addr] = merge(model_mem[addr], wr_val, wr_mask);
            else      exp_q.push_back({1'b0, 1'b1, {DW{1'b0}}});
         end else begin
            rd         = oob ? '0 : model_mem[addr];
            model_data = rd;
            exp_q.push_back({1'b1, oob, rd});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, '0, '0);
   endtask

   // monitor: strobes must appear exactly one edge after the accepted access
   logic [DW+1:0] e;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (started) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (data_valid !== e[DW+1] || oob_err !== e[DW]) begin
                  errors++;
                  $display("FAIL strobes: got valid=%b oob=%b expected valid=%b oob=%b at %0t",
                           data_valid, oob_err, e[DW+1], e[DW], $time);
               end
               if (e[DW+1]) begin
                  checks++;
                  if (data !== e[DW-1:0]) begin
                     errors++;
                     $display("FAIL read_data: got %h expected %h at %0t", data, e[DW-1:0], $time);
                  end
               end
            end else begin
               checks++;
               if (data_valid !== 1'b0 || oob_err !== 1'b0) begin
                  errors++;
                  $display("FAIL spurious: got valid=%b oob=%b expected 0/0 at %0t",
                           data_valid, oob_err, $time);
               end
            end
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks     = 0;
      errors     = 0;
      started    = 1'b0;
      clr_left   = 0;
      model_data = '0;
      reset_dmem = 1'b0;
      req        = 1'b0;
      we         = 1'b0;
      dmem_addr  = '0;
      wr_val     = '0;
      wr_mask    = '0;

      // reset, then requests during clear must be ignored
      drive(1'b1, 1'b0, 1'b0, 0, '0, '0);
      for (int i = 0; i < DEPTH; i++)
         drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 19)), DW'($urandom), MW'($urandom));
      idle(2);

      // legacy write/read
      drive(1'b0, 1'b1, 1'b1, 0, DW'(8'h55), '1);
      drive(1'b0, 1'b1, 1'b0, 0, '0, '0);
      idle(2);

      // back-to-back write then two reads
      drive(1'b0, 1'b1, 1'b1, 3, DW'(8'hA5), '1);
      drive(1'b0, 1'b1, 1'b0, 3, '0, '0);
      drive(1'b0, 1'b1, 1'b0, 7, '0, '0);
      idle(2);

      // out-of-range write and read, no aliasing onto addr 4
      drive(1'b0, 1'b1, 1'b1, 20, DW'(8'h11), '1);
      drive(1'b0, 1'b1, 1'b0, 20, '0, '0);
      drive(1'b0, 1'b1, 1'b0, 4, '0, '0);
      idle(2);

      // reset during an access and again mid-clear
      drive(1'b0, 1'b1, 1'b1, 0, DW'(8'h77), '1);
      drive(1'b1, 1'b1, 1'b0, 0, '0, '0);
      idle(5);
      drive(1'b1, 1'b0, 1'b0, 0, '0, '0);
      idle(DEPTH + 1);
      drive(1'b0, 1'b1, 1'b0, 0, '0, '0);
      idle(2);

      // byte-lane masking (full-word write when masks are not built in)
      drive(1'b0, 1'b1, 1'b1, 2, DW'(16'hFFFF), '1);
      drive(1'b0, 1'b1, 1'b1, 2, DW'(16'h1234), MW'(1));
      drive(1'b0, 1'b1, 1'b0, 2, '0, '0);
      idle(2);

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 19)), DW'($urandom), MW'($urandom));
      idle(DEPTH + 3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
